rail_seq_ctrl: RTL and testbench

RAIL_SEQ_CTRL -- requirements
Module: rail_seq_ctrl

---
 rtl/rail_seq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_rail_seq_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rail_seq_ctrl.sv
// Four-rail power sequencer: staged enable on power-good, reverse-order shutdown, latched faults.
// All outputs registered; transitions land on the edge after their condition; no backpressure.
module rail_seq_ctrl #(
  parameter int PG_TIMEOUT_MS = 50,
  parameter int STAGE_DLY_MS  = 2,
  parameter int OFF_DLY_MS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1ms,
  input  logic       pwr_req,
  input  logic       fault_clr,
  input  logic [3:0] rail_pg,
  output logic [3:0] rail_en,
  output logic       pwr_ok,
  output logic       fault,
  output logic [1:0] fault_rail,
  output logic       fault_type,
  output logic [2:0] seq_state
);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_WAIT_PG = 3'd1,
    S_STG_DLY = 3'd2,
    S_ON      = 3'd3,
    S_OFF_SEQ = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  localparam logic [7:0] PG_TO   = 8'(PG_TIMEOUT_MS);
  localparam logic [7:0] STG_TO  = 8'(STAGE_DLY_MS);
  localparam logic [7:0] OFF_TO  = 8'(OFF_DLY_MS);

  state_t     state, state_d;
  logic [1:0] idx, idx_d, idx_inc, idx_dec;
  logic [7:0] timer;
  logic       tmr_restart;
  logic [3:0] en_d;
  logic       fault_d, ftype_d, pwr_ok_d;
  logic [1:0] frail_d;
  logic [3:0] idx_bit, good_mask, lost;
  logic [1:0] lost_idx;

  assign idx_inc = idx + 2'd1;
  assign idx_dec = idx - 2'd1;
  assign idx_bit = 4'b0001 << idx;

  // Rails already proven good: below idx while waiting, up to idx once idx's rail is good.
  always_comb begin
    good_mask = 4'b0000;
    case (state)
      S_WAIT_PG:       good_mask = idx_bit - 4'd1;
      S_STG_DLY, S_ON: good_mask = (idx_bit - 4'd1) | idx_bit;
      default:         good_mask = 4'b0000;
    endcase
  end

  assign lost = good_mask & ~rail_pg;

  always_comb begin
    lost_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (lost[i]) lost_idx = 2'(i);
    end
  end

  always_comb begin
    state_d     = state;
    idx_d       = idx;
    en_d        = rail_en;
    fault_d     = fault;
    frail_d     = fault_rail;
    ftype_d     = fault_type;
    tmr_restart = 1'b0;

    case (state)
      S_OFF: begin
        if (pwr_req && !fault) begin
          state_d = S_WAIT_PG;
          idx_d   = 2'd0;
          en_d    = 4'b0001;
        end
      end

      S_WAIT_PG, S_STG_DLY, S_ON: begin
        if (|lost) begin
          state_d = S_FAULT;
          en_d    = 4'b0000;
          fault_d = 1'b1;
          frail_d = lost_idx;
          ftype_d = 1'b1;
        end else if (state == S_WAIT_PG && timer == PG_TO && !rail_pg[idx]) begin
          state_d = S_FAULT;
          en_d    = 4'b0000;
          fault_d = 1'b1;
          frail_d = idx;
          ftype_d = 1'b0;
        end else if (!pwr_req) begin
          // idx always names the highest enabled rail in these states
          state_d = S_OFF_SEQ;
          en_d    = rail_en & ~idx_bit;
        end else if (state == S_WAIT_PG && rail_pg[idx]) begin
          state_d = (idx == 2'd3) ? S_ON : S_STG_DLY;
        end else if (state == S_STG_DLY && timer == STG_TO) begin
          state_d = S_WAIT_PG;
          idx_d   = idx_inc;
          en_d    = rail_en | (4'b0001 << idx_inc);
        end
      end

      S_OFF_SEQ: begin
        if (timer == OFF_TO) begin
          if (idx == 2'd0) begin
            state_d = S_OFF;
          end else begin
            idx_d       = idx_dec;
            en_d        = rail_en & ~(4'b0001 << idx_dec);
            tmr_restart = 1'b1;
          end
        end
      end

      S_FAULT: begin
        if (fault_clr && !pwr_req) begin
          state_d = S_OFF;
          fault_d = 1'b0;
          frail_d = 2'd0;
          ftype_d = 1'b0;
        end
      end

      default: state_d = S_OFF;
    endcase
  end

  assign pwr_ok_d = (state_d == S_ON);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_OFF;
      idx        <= 2'd0;
      timer      <= 8'd0;
      rail_en    <= 4'b0000;
      pwr_ok     <= 1'b0;
      fault      <= 1'b0;
      fault_rail <= 2'd0;
      fault_type <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      rail_en    <= en_d;
      pwr_ok     <= pwr_ok_d;
      fault      <= fault_d;
      fault_rail <= frail_d;
      fault_type <= ftype_d;
      if (state_d != state || tmr_restart) begin
        timer <= 8'd0;
      end else if (tick_1ms && timer != 8'hFF) begin
        timer <= timer + 8'd1;
      end
    end
  end

  assign seq_state = state;

endmodule

// File: tb/tb_rail_seq_ctrl.sv
// Bench for rail_seq_ctrl: behavioural rails (pg 3 ticks after enable), tick every 5 clks,
// rail_en transitions scored against an expectation queue.
module tb_rail_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       pwr_req = 1'b0;
  logic       fault_clr = 1'b0;
  logic [3:0] rail_pg;
  logic [3:0] rail_en;
  logic       pwr_ok, fault, fault_type;
  logic [1:0] fault_rail;
  logic [2:0] seq_state;

  logic [3:0] pg_model = 4'b0000;
  logic [3:0] pg_kill  = 4'b0000;
  assign rail_pg = pg_model & ~pg_kill;

  int         errors = 0;
  int         checks = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_e;
  logic [3:0] prev_en = 4'b0000;
  logic       mon_on = 1'b0;

  rail_seq_ctrl dut (
    .clk(clk), .rst(rst), .tick_1ms(tick), .pwr_req(pwr_req), .fault_clr(fault_clr),
    .rail_pg(rail_pg), .rail_en(rail_en), .pwr_ok(pwr_ok), .fault(fault),
    .fault_rail(fault_rail), .fault_type(fault_type), .seq_state(seq_state)
  );

  initial forever #5 clk = ~clk;

  // Rail model and 1 ms tick source, both updated on the falling edge.
  initial begin
    int cnt[4];
    int div;
    div = 0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (rail_en[i] !== 1'b1) begin
          cnt[i] = 0;
          pg_model[i] = 1'b0;
        end else begin
          if (tick && cnt[i] < 3) cnt[i]++;
          pg_model[i] = (cnt[i] >= 3);
        end
      end
      div = (div == 4) ? 0 : div + 1;
      tick = (div == 0);
    end
  end

  // Scoreboard: every change of rail_en must match the next queued expectation.
  initial forever begin
    @(posedge clk);
    #1;
    if (mon_on && rail_en !== prev_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL en_unexpected: got %b, nothing expected", rail_en);
      end else begin
        exp_e = exp_q.pop_front();
        if (rail_en !== exp_e) begin
          errors++;
          $display("FAIL en_seq: got %b expected %b", rail_en, exp_e);
        end
      end
      prev_en = rail_en;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    checks++; if (rail_en !== 4'b0000) begin errors++; $display("FAIL rst_en: got %b expected 0000", rail_en); end
    checks++; if (seq_state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", seq_state); end
    checks++; if (pwr_ok !== 1'b0) begin errors++; $display("FAIL rst_pwr_ok: got %b expected 0", pwr_ok); end
    checks++; if ({fault, fault_rail, fault_type} !== 4'b0000) begin errors++; $display("FAIL rst_fault: got %b expected 0000", {fault, fault_rail, fault_type}); end
    @(negedge clk);
    rst = 1'b0;
    prev_en = 4'b0000;
    mon_on = 1'b1;
  endtask

  task automatic test_power_up();
    int  n;
    bit  ok;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0011);
    exp_q.push_back(4'b0111); exp_q.push_back(4'b1111);
    @(negedge clk);
    pwr_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
        cyc();
        if (rail_pg[i]) begin ok = 1'b1; break; end
      end
      checks++; if (!ok) begin errors++; $display("FAIL up_pg_wait: rail %0d got no pg, expected pg", i); end
      if (i < 3) begin
        checks++; if (seq_state !== 3'd2) begin errors++; $display("FAIL up_stg: rail %0d state %0d expected 2", i, seq_state); end
        n = 0; ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
          cyc();
          if (tick) n++;
          if (rail_en[i+1]) begin ok = 1'b1; break; end
        end
        checks++; if (!ok || n != 2) begin errors++; $display("FAIL up_gap: rail %0d ticks %0d (seen %0d) expected 2", i + 1, n, ok); end
      end else begin
        checks++; if (pwr_ok !== 1'b1 || seq_state !== 3'd3) begin errors++; $display("FAIL up_on: pwr_ok %b state %0d expected 1/3", pwr_ok, seq_state); end
      end
    end
  endtask

  task automatic test_power_down();
    int         n;
    bit         ok;
    logic [3:0] step_v[3];
    step_v[0] = 4'b0011; step_v[1] = 4'b0001; step_v[2] = 4'b0000;
    exp_q.push_back(4'b0111); exp_q.push_back(4'b0011); exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0000); exp_q.push_back(4'b0001);
    @(negedge clk);
    pwr_req = 1'b0;
    cyc();
    checks++; if (seq_state !== 3'd4 || pwr_ok !== 1'b0) begin errors++; $display("FAIL dn_entry: state %0d pwr_ok %b expected 4/0", seq_state, pwr_ok); end
    for (int s = 0; s < 3; s++) begin
      n = 0; ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
        cyc();
        if (tick) n++;
        if (rail_en === step_v[s]) begin ok = 1'b1; break; end
      end
      checks++; if (!ok || n != 1 || seq_state !== 3'd4) begin errors++; $display("FAIL dn_step: step %0d ticks %0d seen %0d state %0d expected 1/1/4", s, n, ok, seq_state); end
      if (s == 0) begin
        @(negedge clk);
        pwr_req = 1'b1;
      end
    end
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      cyc();
      if (seq_state === 3'd0) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || rail_en !== 4'b0000) begin errors++; $display("FAIL dn_off: seen %0d en %b expected OFF 0000", ok, rail_en); end
    cyc();
    checks++; if (seq_state !== 3'd1) begin errors++; $display("FAIL dn_repower: state %0d expected 1", seq_state); end
    exp_q.push_back(4'b0011); exp_q.push_back(4'b0111); exp_q.push_back(4'b1111);
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      cyc();
      if (pwr_ok === 1'b1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL dn_reon: pwr_ok %b expected 1", pwr_ok); end
  endtask

  task automatic test_pg_loss();
    exp_q.push_back(4'b0000);
    @(negedge clk);
    pg_kill = 4'b0010;
    cyc();
    checks++; if (seq_state !== 3'd5 || fault !== 1'b1 || pwr_ok !== 1'b0) begin errors++; $display("FAIL loss_fault: state %0d fault %b pwr_ok %b expected 5/1/0", seq_state, fault, pwr_ok); end
    checks++; if (fault_rail !== 2'd1 || fault_type !== 1'b1) begin errors++; $display("FAIL loss_info: rail %0d type %b expected 1/1", fault_rail, fault_type); end
    @(negedge clk);
    pg_kill = 4'b0000;
    fault_clr = 1'b1;
    cyc();
    checks++; if (seq_state !== 3'd5 || fault !== 1'b1) begin errors++; $display("FAIL loss_clr_ignored: state %0d fault %b expected 5/1", seq_state, fault); end
    @(negedge clk);
    pwr_req = 1'b0;
    cyc();
    checks++; if (seq_state !== 3'd0 || {fault, fault_rail, fault_type} !== 4'b0000) begin errors++; $display("FAIL loss_clr: state %0d fault bits %b expected 0/0000", seq_state, {fault, fault_rail, fault_type}); end
    @(negedge clk);
    fault_clr = 1'b0;
  endtask

  // Powers up to WAIT_PG on rail 2 with rail 2 dead, then runs to the 50th tick after its enable.
  task automatic run_to_timeout(output bit ok);
    int n;
    ok = 1'b0;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0011);
    exp_q.push_back(4'b0111); exp_q.push_back(4'b0000);
    @(negedge clk);
    pg_kill = 4'b0100;
    pwr_req = 1'b1;
    for (int k = 0; k < 300; k++) begin
      cyc();
      if (rail_en === 4'b0111) begin ok = 1'b1; break; end
    end
    n = 0;
    if (ok) begin
      for (int k = 0; k < 400; k++) begin
        cyc();
        if (tick) n++;
        if (n == 50) break;
      end
    end
    ok = ok && (n == 50) && (seq_state === 3'd1);
  endtask

  task automatic clear_fault();
    @(negedge clk);
    pwr_req = 1'b0;
    fault_clr = 1'b1;
    pg_kill = 4'b0000;
    cyc();
    @(negedge clk);
    fault_clr = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok;
    run_to_timeout(ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_wait: state %0d at 50th tick, expected 1", seq_state); end
    cyc();
    checks++; if (seq_state !== 3'd5 || fault !== 1'b1 || rail_en !== 4'b0000) begin errors++; $display("FAIL to_fault: state %0d fault %b en %b expected 5/1/0000", seq_state, fault, rail_en); end
    checks++; if (fault_rail !== 2'd2 || fault_type !== 1'b0) begin errors++; $display("FAIL to_info: rail %0d type %b expected 2/0", fault_rail, fault_type); end
    clear_fault();
    checks++; if (seq_state !== 3'd0 || fault !== 1'b0) begin errors++; $display("FAIL to_clr: state %0d fault %b expected 0/0", seq_state, fault); end
  endtask

  task automatic test_simultaneous();
    bit ok;
    run_to_timeout(ok);
    checks++; if (!ok) begin errors++; $display("FAIL sim_wait: state %0d at 50th tick, expected 1", seq_state); end
    @(negedge clk);
    pg_kill = 4'b0101;
    cyc();
    checks++; if (seq_state !== 3'd5 || fault_type !== 1'b1 || fault_rail !== 2'd0) begin errors++; $display("FAIL sim_prio: state %0d type %b rail %0d expected 5/1/0", seq_state, fault_type, fault_rail); end
    clear_fault();
  endtask

  task automatic test_reset_mid();
    bit ok;
    ok = 1'b0;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0011); exp_q.push_back(4'b0000);
    @(negedge clk);
    pwr_req = 1'b1;
    for (int k = 0; k < 300; k++) begin
      cyc();
      if (seq_state === 3'd2 && rail_en === 4'b0011) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rm_reach: state %0d en %b expected 2/0011", seq_state, rail_en); end
    @(negedge clk);
    rst = 1'b1;
    pwr_req = 1'b0;
    cyc();
    checks++; if (rail_en !== 4'b0000 || seq_state !== 3'd0) begin errors++; $display("FAIL rm_en: en %b state %0d expected 0000/0", rail_en, seq_state); end
    checks++; if ({pwr_ok, fault, fault_rail, fault_type} !== 5'b00000) begin errors++; $display("FAIL rm_outs: got %b expected 00000", {pwr_ok, fault, fault_rail, fault_type}); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) cyc();
    checks++; if (seq_state !== 3'd0 || rail_en !== 4'b0000) begin errors++; $display("FAIL rm_stay: state %0d en %b expected 0/0000", seq_state, rail_en); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_power_down();
    test_pg_loss();
    test_timeout();
    test_simultaneous();
    test_reset_mid();
    repeat (2) cyc();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_drain: %0d pending, expected 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
